demux4_stream: RTL and testbench

Registered 1-to-4 stream router for the RISC-V datapath. It is the steering counterpart of the 4:1 select mux: one producer word, tagged with a 2-bit destination select, is delivered to exactly one of four consumers over valid/ready handshakes. A 2-entry skid buffer keeps `in_ready` registered and sustains one transfer per cycle. Per-destination transfer counters support performance and debug visibility.

---
 rtl/demux4_stream_pkg.sv | 18 +
 rtl/demux4_stream_if.sv | 31 +++
 rtl/demux4_stream_skid_reg2.sv | 89 ++++++++
 rtl/demux4_stream.sv | 60 ++++++
 tb/tb_demux4_stream.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/demux4_stream_pkg.sv
// demux4_pkg: shared types and constants for the demux4_stream router.
//   NUM_OUT  - number of destinations
//   sel_t    - destination index
//   occ_t    - skid buffer occupancy
//   sel_onehot() - destination index to one-hot valid vector
package demux4_pkg;

  localparam int NUM_OUT = 4;

  typedef logic [1:0] sel_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} occ_t;

  function automatic logic [NUM_OUT-1:0] sel_onehot(input sel_t sel);
    return (NUM_OUT)'(1) << sel;
  endfunction

endpackage

// File: rtl/demux4_stream_if.sv
// demux4_stream_if: producer and consumer side stream signals of the router.
//   in_valid/in_ready/in_data/in_sel     - producer handshake and payload
//   out_valid/out_ready/out_data         - one-hot consumer handshake, shared payload
//   xfer_cnt                             - per-destination completed transfer counts
//   modport slave  : router view
//   modport master : environment view
interface demux4_stream_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  import demux4_pkg::*;

  logic                            in_valid;
  logic                            in_ready;
  logic [WIDTH-1:0]                in_data;
  sel_t                            in_sel;
  logic [NUM_OUT-1:0]              out_valid;
  logic [NUM_OUT-1:0]              out_ready;
  logic [WIDTH-1:0]                out_data;
  logic [NUM_OUT-1:0][CNT_W-1:0]   xfer_cnt;

  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_data, xfer_cnt
  );

  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_data, xfer_cnt
  );
endinterface

// File: rtl/demux4_stream_skid_reg2.sv
// skid_reg2: generic 2-entry valid/ready skid buffer.
//   in_valid/in_ready/in_pl    - upstream handshake, in_ready comes from a flop
//   out_valid/out_ready/out_pl - downstream handshake, driven by main register M
// Words leave in acceptance order; one transfer per cycle when downstream ready.
//
// state | meaning
// EMPTY | M and S empty, in_ready = 1
// ONE   | M holds the head word, S empty, in_ready = 1
// TWO   | M holds the head word, S holds the next, in_ready = 0
module skid_reg2
  import demux4_pkg::*;
#(
  parameter int PW = 34
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_pl,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] out_pl
);

  occ_t          state_q, state_d;
  logic          m_valid_q, in_ready_q;
  logic [PW-1:0] m_q, s_q;
  logic          in_fire, out_fire;
  logic          load_m_in, load_m_s, load_s;

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = m_valid_q & out_ready;

  always_comb begin
    state_d   = state_q;
    load_m_in = 1'b0;
    load_m_s  = 1'b0;
    load_s    = 1'b0;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d   = ONE;
          load_m_in = 1'b1;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          load_m_in = 1'b1;
        end else if (out_fire) begin
          state_d = EMPTY;
        end else if (in_fire) begin
          state_d = TWO;
          load_s  = 1'b1;
        end
      end
      TWO: begin
        if (out_fire) begin
          state_d  = ONE;
          load_m_s = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Valid and ready flags are flopped from the next state so the outputs
  // come straight from registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      m_valid_q  <= 1'b0;
      in_ready_q <= 1'b1;
      m_q        <= '0;
      s_q        <= '0;
    end else begin
      state_q    <= state_d;
      m_valid_q  <= (state_d != EMPTY);
      in_ready_q <= (state_d != TWO);
      if (load_m_in)     m_q <= in_pl;
      else if (load_m_s) m_q <= s_q;
      if (load_s)        s_q <= in_pl;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = m_valid_q;
  assign out_pl    = m_q;

endmodule

// File: rtl/demux4_stream.sv
// demux4_stream: registered 1-to-4 stream router.
//   clk, rst_n - clock, async active-low reset
//   bus        - demux4_stream_if slave: producer stream in, one-hot
//                consumer stream out, per-destination transfer counters
// A word tagged with in_sel goes to exactly one destination, in acceptance
// order; a stalled destination blocks the rest.
module demux4_stream
  import demux4_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  demux4_stream_if.slave bus
);

  localparam int PW = $bits(sel_t) + WIDTH;

  logic                          m_valid;
  logic                          m_ready;
  logic [PW-1:0]                 m_pl;
  sel_t                          m_sel;
  logic [WIDTH-1:0]              m_data;
  logic                          out_fire;
  logic [NUM_OUT-1:0][CNT_W-1:0] cnt_q;

  skid_reg2 #(.PW(PW)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_pl     ({bus.in_sel, bus.in_data}),
    .out_valid (m_valid),
    .out_ready (m_ready),
    .out_pl    (m_pl)
  );

  assign {m_sel, m_data} = m_pl;

  // Only the selected destination's ready matters.
  assign m_ready  = bus.out_ready[m_sel];
  assign out_fire = m_valid & m_ready;

  assign bus.out_valid = m_valid ? sel_onehot(m_sel) : '0;
  assign bus.out_data  = m_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      for (int k = 0; k < NUM_OUT; k++) begin
        if (out_fire && (m_sel == sel_t'(k))) cnt_q[k] <= cnt_q[k] + CNT_W'(1);
      end
    end
  end

  assign bus.xfer_cnt = cnt_q;

endmodule

// File: tb/tb_demux4_stream.sv
module tb_demux4_stream;
  import demux4_pkg::*;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  demux4_stream_if #(.WIDTH(32), .CNT_W(16)) bus ();
  demux4_stream_if #(.WIDTH(32), .CNT_W(4))  bus_w ();

  demux4_stream #(.WIDTH(32), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  demux4_stream #(.WIDTH(32), .CNT_W(4)) dut_w (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input sel_t s, input logic [31:0] d);
    bus.in_valid = v;
    bus.in_sel   = s;
    bus.in_data  = d;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    bus.in_valid    = 1'($urandom_range(0, 1));
    bus.in_sel      = sel_t'($urandom_range(0, 3));
    bus.in_data     = $urandom;
    bus.out_ready   = 4'($urandom_range(0, 15));
    bus_w.in_valid  = 1'b0;
    bus_w.in_sel    = 2'd0;
    bus_w.in_data   = 32'd0;
    bus_w.out_ready = 4'h0;

    // Reset with random inputs
    repeat (3) step();
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data", 64'(bus.out_data), 64'd0);
    chk("rst_xfer_cnt", bus.xfer_cnt, 64'd0);

    drive(1'b0, 2'd0, 32'd0);
    bus.out_ready = 4'h0;
    #2 rst_n = 1'b1;
    step();

    // Single word
    drive(1'b1, 2'd2, 32'hDEADBEEF);
    bus.out_ready = 4'hF;
    step();
    chk("single_out_valid", 64'(bus.out_valid), 64'h4);
    chk("single_out_data", 64'(bus.out_data), 64'hDEADBEEF);
    drive(1'b0, 2'd0, 32'd0);
    step();
    chk("single_out_valid_idle", 64'(bus.out_valid), 64'h0);
    chk("single_cnt2", 64'(bus.xfer_cnt[2]), 64'd1);
    chk("single_cnt_others", {bus.xfer_cnt[3], bus.xfer_cnt[1], bus.xfer_cnt[0]}, 64'd0);

    // Backpressure: A(sel0), B(sel1), C(sel3)
    bus.out_ready = 4'h0;
    drive(1'b1, 2'd0, 32'hA000_000A);
    step();
    chk("bp_a_in_ready", 64'(bus.in_ready), 64'd1);
    chk("bp_a_out_valid", 64'(bus.out_valid), 64'h1);
    drive(1'b1, 2'd1, 32'hB000_000B);
    step();
    chk("bp_b_in_ready", 64'(bus.in_ready), 64'd0);
    chk("bp_b_head_data", 64'(bus.out_data), 64'hA000_000A);
    drive(1'b1, 2'd3, 32'hC000_000C);
    step();
    chk("bp_c_held_in_ready", 64'(bus.in_ready), 64'd0);
    chk("bp_c_held_out_valid", 64'(bus.out_valid), 64'h1);
    chk("bp_c_held_data", 64'(bus.out_data), 64'hA000_000A);
    bus.out_ready = 4'hF;
    step();
    chk("bp_deliver_b_valid", 64'(bus.out_valid), 64'h2);
    chk("bp_deliver_b_data", 64'(bus.out_data), 64'hB000_000B);
    chk("bp_in_ready_back", 64'(bus.in_ready), 64'd1);
    step();
    chk("bp_deliver_c_valid", 64'(bus.out_valid), 64'h8);
    chk("bp_deliver_c_data", 64'(bus.out_data), 64'hC000_000C);
    drive(1'b0, 2'd0, 32'd0);
    step();
    chk("bp_drained", 64'(bus.out_valid), 64'h0);
    chk("bp_cnt", bus.xfer_cnt, {16'd1, 16'd1, 16'd1, 16'd1});

    // Streaming 8 words, one per cycle
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, sel_t'(i % 4), 32'h1000 + 32'(i));
      step();
      chk($sformatf("stream_valid_%0d", i), 64'(bus.out_valid), 64'(1) << (i % 4));
      chk($sformatf("stream_data_%0d", i), 64'(bus.out_data), 64'h1000 + 64'(i));
      chk($sformatf("stream_in_ready_%0d", i), 64'(bus.in_ready), 64'd1);
    end
    drive(1'b0, 2'd0, 32'd0);
    step();
    chk("stream_drained", 64'(bus.out_valid), 64'h0);
    chk("stream_cnt", bus.xfer_cnt, {16'd3, 16'd3, 16'd3, 16'd3});

    // Counter wrap at CNT_W = 4: 17 words to destination 3
    bus_w.out_ready = 4'hF;
    bus_w.in_valid  = 1'b1;
    bus_w.in_sel    = 2'd3;
    for (int i = 0; i < 17; i++) begin
      bus_w.in_data = 32'(i);
      step();
    end
    bus_w.in_valid = 1'b0;
    step();
    chk("wrap_out_valid", 64'(bus_w.out_valid), 64'h0);
    chk("wrap_cnt3", 64'(bus_w.xfer_cnt[3]), 64'd1);
    chk("wrap_cnt_others", 64'({bus_w.xfer_cnt[2], bus_w.xfer_cnt[1], bus_w.xfer_cnt[0]}), 64'd0);

    // Reset while in TWO
    bus.out_ready = 4'h0;
    drive(1'b1, 2'd1, 32'h5555_0001);
    step();
    drive(1'b1, 2'd2, 32'h5555_0002);
    step();
    chk("two_in_ready", 64'(bus.in_ready), 64'd0);
    chk("two_out_valid", 64'(bus.out_valid), 64'h2);
    drive(1'b0, 2'd0, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(bus.out_valid), 64'h0);
    chk("arst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("arst_out_data", 64'(bus.out_data), 64'd0);
    chk("arst_cnt", bus.xfer_cnt, 64'd0);
    bus.out_ready = 4'hF;
    step();
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("post_rst_idle_%0d", i), 64'(bus.out_valid), 64'h0);
    end
    drive(1'b1, 2'd0, 32'h7777_0000);
    step();
    chk("post_rst_new_valid", 64'(bus.out_valid), 64'h1);
    chk("post_rst_new_data", 64'(bus.out_data), 64'h7777_0000);
    drive(1'b0, 2'd0, 32'd0);
    step();
    chk("post_rst_cnt0", 64'(bus.xfer_cnt[0]), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
